bcd_down_timer: RTL and testbench

Parametrised multi-digit BCD down-counter for the microwave timer path. It replaces chained single-digit MOD10 counters with one block that has a configurable digit count and a per-digit modulus, so mm:ss and similar formats come from parameters alone. It loads a preset, decrements once per enable tick with an internal borrow chain, reports zero and terminal count, emits a one-cycle `done` pulse on reaching zero, and flags out-of-range preset digits.

---
 rtl/bcd_down_timer.sv | 88 ++++++++
 tb/tb_bcd_down_timer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD down-counter with per-digit modulus, clamp-on-load and done pulse.
// Define BCD_DOWN_TIMER_HOLD_AT_ZERO_EN to hold at zero instead of wrapping.
module bcd_down_timer #(
    parameter int          NDIG    = 4,
    parameter logic [31:0] MOD_VEC = 32'h0000_6A6A
) (
    input  logic              clock,
    input  logic              clrn,
    input  logic              loadn,
    input  logic              enable,
    input  logic [4*NDIG-1:0] data,
    output logic [4*NDIG-1:0] digits,
    output logic              zero,
    output logic              tc,
    output logic              done,
    output logic              load_err
);

    logic [4*NDIG-1:0] digits_q, digits_d;
    logic              done_q, done_d;
    logic              load_err_q, load_err_d;
    logic              count_en;
    logic              borrow;
    logic              clamp;
    logic [3:0]        mod_i;
    logic [3:0]        cur;

    assign zero = (digits_q == '0);
    assign tc   = zero & enable;

`ifdef BCD_DOWN_TIMER_HOLD_AT_ZERO_EN
    assign count_en = ~zero;
`else
    assign count_en = 1'b1;
`endif

    always_comb begin
        digits_d   = digits_q;
        done_d     = 1'b0;
        load_err_d = load_err_q;
        clamp      = 1'b0;
        borrow     = 1'b1;
        mod_i      = '0;
        cur        = '0;
        if (!loadn) begin
            for (int i = 0; i < NDIG; i++) begin
                mod_i = MOD_VEC[4*i +: 4];
                cur   = data[4*i +: 4];
                if (cur >= mod_i) begin
                    digits_d[4*i +: 4] = mod_i - 4'd1;
                    clamp              = 1'b1;
                end else begin
                    digits_d[4*i +: 4] = cur;
                end
            end
            load_err_d = clamp;
        end else if (enable && count_en) begin
            // borrow propagates upward only while every lower digit is zero
            for (int i = 0; i < NDIG; i++) begin
                mod_i = MOD_VEC[4*i +: 4];
                cur   = digits_q[4*i +: 4];
                if (borrow) begin
                    digits_d[4*i +: 4] = (cur == 4'd0) ? mod_i - 4'd1
                                                       : cur - 4'd1;
                end
                borrow = borrow & (cur == 4'd0);
            end
            done_d = ~zero & (digits_d == '0);
        end
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            digits_q   <= '0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            digits_q   <= digits_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign digits   = digits_q;
    assign done     = done_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Self-checking bench for bcd_down_timer (default mm:ss configuration).
// Reference model keeps the count as a total of seconds in mixed radix.
module tb_bcd_down_timer;

    logic        clock;
    logic        clrn;
    logic        loadn;
    logic        enable;
    logic [15:0] data;
    logic [15:0] digits;
    logic        zero;
    logic        tc;
    logic        done;
    logic        load_err;

    int errors = 0;
    int checks = 0;

    int mods[4] = '{10, 6, 10, 6};
    int total = 3600;
    int m_n = 0;
    logic m_done = 1'b0;
    logic m_err = 1'b0;

    bcd_down_timer dut (
        .clock   (clock),
        .clrn    (clrn),
        .loadn   (loadn),
        .enable  (enable),
        .data    (data),
        .digits  (digits),
        .zero    (zero),
        .tc      (tc),
        .done    (done),
        .load_err(load_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] to_digits(input int n);
        logic [15:0] r;
        int v;
        r = '0;
        v = n;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % mods[i]);
            v = v / mods[i];
        end
        return r;
    endfunction

    function automatic int from_data(input logic [15:0] d, output logic err);
        int n, w, v;
        n = 0;
        w = 1;
        err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v = int'(d[4*i +: 4]);
            if (v >= mods[i]) begin
                v = mods[i] - 1;
                err = 1'b1;
            end
            n = n + v * w;
            w = w * mods[i];
        end
        return n;
    endfunction

    task automatic drive(input logic ld, input logic en, input logic [15:0] d);
        loadn  = ld;
        enable = en;
        data   = d;
    endtask

    // Advance one edge and apply the same edge to the model
    task automatic clk_model();
        logic e;
        int n;
        @(posedge clock);
        #1;
        if (!clrn) begin
            m_n = 0;
            m_done = 1'b0;
            m_err = 1'b0;
        end else if (!loadn) begin
            n = from_data(data, e);
            m_n = n;
            m_err = e;
            m_done = 1'b0;
        end else if (enable) begin
            if (m_n == 0) begin
`ifndef BCD_DOWN_TIMER_HOLD_AT_ZERO_EN
                m_n = total - 1;
`endif
                m_done = 1'b0;
            end else begin
                m_n = m_n - 1;
                m_done = (m_n == 0);
            end
        end else begin
            m_done = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (digits !== 16'h0000) begin
            errors++;
            $display("FAIL reset_digits got=%h want=%h", digits, 16'h0000);
        end
        clrn = 1'b1;
        drive(1'b0, 1'b0, 16'h7A9C);
        clk_model();
        drive(1'b1, 1'b1, 16'h0000);
        clk_model();
        checks++;
        if (load_err !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_err got=%b want=1", load_err);
        end
        #2;
        clrn = 1'b0;
        m_n = 0;
        m_done = 1'b0;
        m_err = 1'b0;
        #1;
        checks++;
        if (digits !== 16'h0000 || zero !== 1'b1) begin
            errors++;
            $display("FAIL async_reset digits=%h zero=%b want 0000/1", digits, zero);
        end
        checks++;
        if (done !== 1'b0 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_flags done=%b err=%b want 0/0", done, load_err);
        end
        checks++;
        if (tc !== 1'b1) begin
            errors++;
            $display("FAIL reset_tc got=%b want=1", tc);
        end
        clrn = 1'b1;
        clk_model();
        checks++;
        if (digits !== to_digits(m_n)) begin
            errors++;
            $display("FAIL release_edge got=%h want=%h", digits, to_digits(m_n));
        end
    endtask

    task automatic test_countdown();
        int done_cnt;
        done_cnt = 0;
        drive(1'b0, 1'b0, 16'h0130);
        clk_model();
        checks++;
        if (digits !== 16'h0130 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL cd_load got=%h err=%b want=0130/0", digits, load_err);
        end
        for (int k = 1; k <= 90; k++) begin
            drive(1'b1, 1'b1, 16'h0000);
            #1;
            checks++;
            if (tc !== (m_n == 0)) begin
                errors++;
                $display("FAIL cd_tc tick=%0d got=%b want=%b", k, tc, m_n == 0);
            end
            clk_model();
            checks++;
            if (digits !== to_digits(m_n) || done !== m_done) begin
                errors++;
                $display("FAIL cd_tick=%0d got=%h/%b want=%h/%b",
                         k, digits, done, to_digits(m_n), m_done);
            end
            if (done === 1'b1) done_cnt++;
        end
        checks++;
        if (digits !== 16'h0000 || zero !== 1'b1) begin
            errors++;
            $display("FAIL cd_end got=%h zero=%b want=0000/1", digits, zero);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL cd_done_count got=%0d want=1", done_cnt);
        end
        drive(1'b1, 1'b0, 16'h0000);
        clk_model();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL cd_done_fall got=%b want=0", done);
        end
        drive(1'b1, 1'b1, 16'h0000);
        #1;
        checks++;
        if (tc !== 1'b1) begin
            errors++;
            $display("FAIL cd_tc_zero got=%b want=1", tc);
        end
        drive(1'b1, 1'b0, 16'h0000);
        #1;
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("FAIL cd_tc_noen got=%b want=0", tc);
        end
    endtask

    task automatic test_borrow();
        drive(1'b0, 1'b0, 16'h1000);
        clk_model();
        drive(1'b1, 1'b1, 16'h0000);
        clk_model();
        checks++;
        if (digits !== 16'h0959 || digits !== to_digits(m_n)) begin
            errors++;
            $display("FAIL borrow_1000 got=%h want=%h", digits, 16'h0959);
        end
        drive(1'b0, 1'b0, 16'h0100);
        clk_model();
        drive(1'b1, 1'b1, 16'h0000);
        clk_model();
        checks++;
        if (digits !== 16'h0059) begin
            errors++;
            $display("FAIL borrow_0100 got=%h want=%h", digits, 16'h0059);
        end
    endtask

    task automatic test_clamp();
        drive(1'b0, 1'b0, 16'h7A9C);
        clk_model();
        checks++;
        if (digits !== 16'h5959 || load_err !== 1'b1) begin
            errors++;
            $display("FAIL clamp got=%h err=%b want=5959/1", digits, load_err);
        end
        drive(1'b1, 1'b1, 16'h0000);
        clk_model();
        checks++;
        if (load_err !== 1'b1 || digits !== to_digits(m_n)) begin
            errors++;
            $display("FAIL clamp_hold got=%h err=%b want=%h/1",
                     digits, load_err, to_digits(m_n));
        end
        drive(1'b0, 1'b0, 16'h0010);
        clk_model();
        checks++;
        if (digits !== 16'h0010 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL clamp_clear got=%h err=%b want=0010/0", digits, load_err);
        end
    endtask

    task automatic test_priority();
        drive(1'b0, 1'b1, 16'h0005);
        clk_model();
        checks++;
        if (digits !== 16'h0005) begin
            errors++;
            $display("FAIL prio_load got=%h want=0005", digits);
        end
        drive(1'b1, 1'b1, 16'h0000);
        repeat (4) clk_model();
        drive(1'b0, 1'b1, 16'h0000);
        clk_model();
        checks++;
        if (digits !== 16'h0000 || done !== 1'b0) begin
            errors++;
            $display("FAIL prio_zero_load got=%h done=%b want=0000/0", digits, done);
        end
    endtask

    task automatic test_zero();
        logic [15:0] exp_seq[3];
`ifdef BCD_DOWN_TIMER_HOLD_AT_ZERO_EN
        exp_seq = '{16'h0000, 16'h0000, 16'h0000};
`else
        exp_seq = '{16'h5959, 16'h5958, 16'h5957};
`endif
        drive(1'b0, 1'b0, 16'h0000);
        clk_model();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 16'h0000);
            clk_model();
            checks++;
            if (digits !== exp_seq[k] || done !== 1'b0 ||
                digits !== to_digits(m_n)) begin
                errors++;
                $display("FAIL zero_tick=%0d got=%h done=%b want=%h/0",
                         k, digits, done, exp_seq[k]);
            end
        end
    endtask

    task automatic test_random();
        logic ld, en;
        logic [15:0] d;
        for (int k = 0; k < 400; k++) begin
            ld = ($urandom_range(0, 9) != 0);
            en = ($urandom_range(0, 3) != 0);
            d  = 16'($urandom);
            if ($urandom_range(0, 1) == 0) d = to_digits($urandom_range(0, 5));
            drive(ld, en, d);
            #1;
            checks++;
            if (tc !== ((m_n == 0) && en) || zero !== (m_n == 0)) begin
                errors++;
                $display("FAIL rnd_comb step=%0d tc=%b zero=%b want=%b/%b",
                         k, tc, zero, (m_n == 0) && en, m_n == 0);
            end
            clk_model();
            checks++;
            if (digits !== to_digits(m_n) || done !== m_done || load_err !== m_err) begin
                errors++;
                $display("FAIL rnd step=%0d got=%h/%b/%b want=%h/%b/%b", k,
                         digits, done, load_err, to_digits(m_n), m_done, m_err);
            end
        end
    endtask

    initial begin
        clrn   = 1'b0;
        loadn  = 1'b1;
        enable = 1'b0;
        data   = '0;
        test_reset();
        test_countdown();
        test_borrow();
        test_clamp();
        test_priority();
        test_zero();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
